// File: rtl/bias_mem_pkg.sv
// Shared constants, FSM state type and sign-magnitude to two's-complement helper
// for the layer bias store.
package bias_mem_pkg;

   localparam int DEF_N_NEURONS = 10;
   localparam int DEF_WIDTH     = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Negative zero maps to 0 because the negated magnitude wraps to zero.
   function automatic logic [63:0] sm_to_tc(input logic [63:0] value, input int width);
      logic [63:0] mag_mask;
      logic [63:0] word_mask;
      logic [63:0] mag;
      logic        neg;
      mag_mask  = (64'd1 << (width - 1)) - 64'd1;
      word_mask = (mag_mask << 1) | 64'd1;
      mag       = value & mag_mask;
      neg       = ((value >> (width - 1)) & 64'd1) != 64'd0;
      if (neg) begin
         return ((~mag) + 64'd1) & word_mask;
      end
      return mag;
   endfunction

endpackage

// File: rtl/sm_to_tc_conv.sv
// Combinational sign-magnitude to two's-complement converter.
// Only compiled when BIAS_STREAM_TC_EN is defined.
`ifdef BIAS_STREAM_TC_EN
module sm_to_tc_conv
   import bias_mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] sm,
   output logic [WIDTH-1:0] tc
);

   logic [63:0] tc_wide;

   assign tc_wide = sm_to_tc(64'(sm), WIDTH);
   assign tc      = tc_wide[WIDTH-1:0];

endmodule
`endif

// File: rtl/bias_stream_mem.sv
// Writable sign-magnitude bias store for one FNN layer, streamed in index order
// over valid/ready. Define BIAS_STREAM_TC_EN to present biases in two's complement.
//
// state  | meaning
// IDLE   | no stream in progress, output register empty
// STREAM | output register holds entry out_idx, waiting for / taking handshakes
module bias_stream_mem
   import bias_mem_pkg::*;
#(
   parameter int N_NEURONS = DEF_N_NEURONS,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int AW        = $clog2(N_NEURONS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_err,
   input  logic             start,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_idx,
   output logic             out_last
);

   localparam logic [AW-1:0] LAST_IDX  = AW'(N_NEURONS - 1);
   localparam logic [AW:0]   N_ENTRIES = (AW + 1)'(N_NEURONS);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [N_NEURONS];
   logic [WIDTH-1:0] data_q;
   logic [AW-1:0]    idx_q;
   logic             wr_err_q;

   logic             wr_ok;
   logic             load_en;
   logic             clear_out;
   logic [AW-1:0]    load_idx;
   logic [WIDTH-1:0] load_val;

   // Compare one bit wider so a power-of-two depth does not wrap the limit to 0.
   assign wr_ok = wr_en && ({1'b0, wr_addr} < N_ENTRIES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            mem_q[i] <= '0;
         end
         wr_err_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
         end
         wr_err_q <= wr_en && !wr_ok;
      end
   end

   always_comb begin
      state_d   = state_q;
      load_en   = 1'b0;
      clear_out = 1'b0;
      load_idx  = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = STREAM;
               load_en = 1'b1;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  if (start) begin
                     load_en = 1'b1;
                  end else begin
                     state_d   = IDLE;
                     clear_out = 1'b1;
                  end
               end else begin
                  load_en  = 1'b1;
                  load_idx = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A write landing on the entry being loaded this edge wins over the stored copy.
   assign load_val = (wr_ok && (wr_addr == load_idx)) ? wr_data : mem_q[load_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_en) begin
            idx_q  <= load_idx;
            data_q <= load_val;
         end else if (clear_out) begin
            idx_q  <= '0;
            data_q <= '0;
         end
      end
   end

   assign out_valid = (state_q == STREAM);
   assign busy      = (state_q == STREAM);
   assign out_idx   = idx_q;
   assign out_last  = out_valid && (idx_q == LAST_IDX);
   assign wr_err    = wr_err_q;

`ifdef BIAS_STREAM_TC_EN
   sm_to_tc_conv #(
      .WIDTH(WIDTH)
   ) u_conv (
      .sm(data_q),
      .tc(out_data)
   );
`else
   assign out_data = data_q;
`endif

endmodule

// File: tb/tb_bias_stream_mem.sv
// Directed self-checking bench for bias_stream_mem (N_NEURONS=10, WIDTH=8).
module tb_bias_stream_mem;

   localparam int N  = 10;
   localparam int W  = 8;
   localparam int AW = 4;

   typedef struct {
      logic [AW-1:0] idx;
      logic [W-1:0]  wdata;
      logic [W-1:0]  exp;
      logic          last;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          wr_err;
   logic          start;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [AW-1:0] out_idx;
   logic          out_last;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] model [N];
   vec_t         vt [N];

   bias_stream_mem #(
      .N_NEURONS(N),
      .WIDTH(W),
      .AW(AW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_err(wr_err),
      .start(start),
      .busy(busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_idx(out_idx),
      .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] exp_out(input logic [W-1:0] raw);
`ifdef BIAS_STREAM_TC_EN
      if (raw[W-1]) return 8'h00 - {1'b0, raw[W-2:0]};
`endif
      return raw;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_beat(input int i, input logic [W-1:0] e);
      check($sformatf("valid[%0d]", i), 32'(out_valid), 32'd1);
      check($sformatf("busy[%0d]", i),  32'(busy),      32'd1);
      check($sformatf("idx[%0d]", i),   32'(out_idx),   32'(i));
      check($sformatf("data[%0d]", i),  32'(out_data),  32'(e));
      check($sformatf("last[%0d]", i),  32'(out_last),  32'(i == N - 1));
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid"}, 32'(out_valid), 32'd0);
      check({tag, " busy"},  32'(busy),      32'd0);
      check({tag, " last"},  32'(out_last),  32'd0);
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic plain_stream(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check_beat(i, exp_out(model[i]));
         tick();
      end
      check_idle(tag);
   endtask

   initial begin
      logic [W-1:0] load_vals [N] = '{8'h83, 8'hAE, 8'h23, 8'h02, 8'h15,
                                      8'h03, 8'h9F, 8'hC6, 8'h56, 8'h07};
`ifdef BIAS_STREAM_TC_EN
      logic [W-1:0] exp_vals [N] = '{8'hFD, 8'hD2, 8'h23, 8'h02, 8'h15,
                                     8'h03, 8'hE1, 8'hBA, 8'h56, 8'h07};
`else
      logic [W-1:0] exp_vals [N] = '{8'h83, 8'hAE, 8'h23, 8'h02, 8'h15,
                                     8'h03, 8'h9F, 8'hC6, 8'h56, 8'h07};
`endif
      logic [W-1:0] held;

      for (int i = 0; i < N; i++) begin
         vt[i].idx   = AW'(i);
         vt[i].wdata = load_vals[i];
         vt[i].exp   = exp_vals[i];
         vt[i].last  = (i == N - 1);
      end

      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check_idle("reset");
      check("reset data",   32'(out_data), 32'd0);
      check("reset idx",    32'(out_idx),  32'd0);
      check("reset wr_err", 32'(wr_err),   32'd0);
      rst_n = 1'b1;
      tick();

      // Load and table-driven stream at full throughput
      for (int i = 0; i < N; i++) begin
         write(vt[i].idx, vt[i].wdata);
         model[i] = vt[i].wdata;
      end
      check("load wr_err", 32'(wr_err), 32'd0);
      check_idle("pre-start");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check($sformatf("tbl valid[%0d]", i), 32'(out_valid), 32'd1);
         check($sformatf("tbl busy[%0d]", i),  32'(busy),      32'd1);
         check($sformatf("tbl idx[%0d]", i),   32'(out_idx),   32'(vt[i].idx));
         check($sformatf("tbl data[%0d]", i),  32'(out_data),  32'(vt[i].exp));
         check($sformatf("tbl last[%0d]", i),  32'(out_last),  32'(vt[i].last));
         tick();
      end
      check_idle("tbl end");

      // Backpressure on idx 4
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check_beat(i, exp_out(model[i]));
         if (i == 4) begin
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               tick();
               check($sformatf("bp idx hold %0d", k),  32'(out_idx),   32'd4);
               check($sformatf("bp data hold %0d", k), 32'(out_data),  32'(exp_out(model[4])));
               check($sformatf("bp valid %0d", k),     32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
         end
         tick();
      end
      check_idle("bp end");

      // Collision forwarding on idx 3, snapshot on idx 4
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check_beat(i, exp_out(model[i]));
         if (i == 2) begin
            wr_en    = 1'b1;
            wr_addr  = 4'd3;
            wr_data  = 8'h11;
            model[3] = 8'h11;
         end
         if (i == 4) begin
            held      = out_data;
            out_ready = 1'b0;
            wr_en     = 1'b1;
            wr_addr   = 4'd4;
            wr_data   = 8'h55;
            tick();
            wr_en = 1'b0;
            check("snapshot data", 32'(out_data), 32'(held));
            model[4]  = 8'h55;
            out_ready = 1'b1;
         end
         tick();
         wr_en = 1'b0;
      end
      check_idle("coll end");

      // Out-of-range write
      write(4'd12, 8'hFF);
      check("oor wr_err pulse", 32'(wr_err), 32'd1);
      tick();
      check("oor wr_err clear", 32'(wr_err), 32'd0);
      plain_stream("oor end");

      // Mid-stream start ignored, start on last handshake chains a new stream
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check_beat(i, exp_out(model[i]));
         if (i == 5 || i == N - 1) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check_beat(0, exp_out(model[0]));
      tick();
      for (int i = 1; i < N; i++) begin
         check_beat(i, exp_out(model[i]));
         tick();
      end
      check_idle("b2b end");

      // Reset during idx 6
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("pre-rst idx", 32'(out_idx), 32'd6);
      rst_n = 1'b0;
      #1;
      check_idle("async rst");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) model[i] = '0;
      tick();
      plain_stream("post-rst end");

      // Negative zero and a negative value
      write(4'd0, 8'h80);
      write(4'd1, 8'h85);
      model[0] = 8'h80;
      model[1] = 8'h85;
`ifdef BIAS_STREAM_TC_EN
      check("tc negzero model", 32'(exp_out(model[0])), 32'h00);
`endif
      plain_stream("negzero end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bias_stream_mem.md
Name: bias_stream_mem

Overview:
- Parametrised, writable bias store for one FNN layer, feeding the layer's MAC/accumulate stage.
- Holds N_NEURONS sign-magnitude biases: bit WIDTH-1 is the sign, the remaining bits are the magnitude.
- Loaded at run time through a write port; streams biases in index order on start, over a valid/ready handshake.
- Replaces fixed per-layer constant bias tables.

Parameters:
- N_NEURONS, 10, number of bias entries (>=2).
- WIDTH, 8, bits per bias, sign-magnitude.
- AW, $clog2(N_NEURONS), address/index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write index.
- wr_data  in  WIDTH  bias value to store.
- wr_err  out  1  one-cycle pulse: write address out of range.
- start  in  1  request a full stream of all entries.
- busy  out  1  high while streaming.
- out_valid  out  1  out_data/out_idx/out_last are valid.
- out_ready  in  1  consumer accepts the current entry.
- out_data  out  WIDTH  bias value.
- out_idx  out  AW  index of out_data.
- out_last  out  1  out_idx == N_NEURONS-1.

Behaviour:
- Reset (async assert, sync release): all entries 0, FSM IDLE, and out_valid/out_data/out_idx/out_last/busy/wr_err all 0.
- Write:
  - wr_en with wr_addr < N_NEURONS stores wr_data at the clock edge.
  - wr_addr >= N_NEURONS: no store; wr_err=1 the next cycle, for one cycle only.
  - Writes are legal in any state.
- FSM IDLE:
  - out_valid=0, busy=0.
  - start=1 -> STREAM; at the next edge entry 0 loads into the output register, out_valid=1, out_idx=0, busy=1.
  - Latency is 1 cycle from start to first valid.
- FSM STREAM:
  - Output fields are held stable while out_valid && !out_ready.
  - Handshake (out_valid && out_ready) on entry i < N-1 -> entry i+1 loads at the same edge. No bubbles; 1 entry/cycle at full throughput.
  - Handshake on the last entry, start=0 -> IDLE; out_valid=0, busy=0, out_last=0 next cycle.
  - Handshake on the last entry, start=1 -> stay in STREAM and load entry 0 next cycle (back-to-back streams).
  - start in STREAM other than on the last handshake: ignored, not queued.
- Write/read collision: if a write targets the entry being loaded at the same edge, the loaded value is wr_data (write-forwarding).
- The output register is a snapshot: later writes to an entry already presented do not change out_data.
- out_last = (out_idx == N_NEURONS-1) && out_valid.
- Reset mid-stream: immediate abort to reset state; entry contents also cleared.

Optional Feature:
- Macro BIAS_STREAM_TC_EN.
- Defined: out_data is the two's-complement conversion of the stored value.
  - Negative: -(magnitude).
  - Negative zero (1 followed by zeros) -> 0.
  - Width unchanged; no overflow is possible.
  - Conversion is combinational on the stored value, so latency is unchanged.
- Undefined: out_data is the raw sign-magnitude value.
- Storage is always sign-magnitude.

Decomposition:
- Package bias_mem_pkg contains:
  - Default WIDTH and N_NEURONS constants.
  - FSM state enum {IDLE, STREAM}.
  - Function sm_to_tc(value, width).
- Sub-module sm_to_tc_conv (combinational, WIDTH-parametrised), instantiated only under BIAS_STREAM_TC_EN.

Test Plan:
- Load and stream:
  - Stimulus: write 0x83,0xAE,0x23,0x02,0x15,0x03,0x9F,0xC6,0x56,0x07 to idx 0..9; start; out_ready=1.
  - Response: out_valid from the cycle after start; 10 consecutive beats idx 0..9 with those values; out_last only on idx 9; busy falls the cycle after beat 9.
- TC mode (BIAS_STREAM_TC_EN):
  - Stimulus: same load.
  - Response: beats 0xFD,0xD2,0x23,0x02,0x15,0x03,0xE1,0xBA,0x56,0x07.
  - Extra: an entry written 0x80 streams as 0x00.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles on idx 4.
  - Response: out_data/out_idx stay stable for those cycles; idx 5 appears the cycle after ready rises.
- Collision and out-of-range:
  - Write 0x11 to idx 3 in the same cycle idx 3 loads -> out_data=0x11.
  - Write to idx 12 -> wr_err pulses once; no entry changes.
- Back-to-back start:
  - Stimulus: start asserted with the last handshake.
  - Response: idx 0 presented the next cycle; busy stays 1.
  - Also: start mid-stream has no effect.
- Reset mid-stream:
  - Stimulus: rst_n low during idx 6.
  - Response: out_valid/busy drop immediately.
  - After release: a new stream returns all zeros.
